// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl -- PS/2 Set-2 keyboard scan-code sequencer.
//
// Takes bytes from the PS/2 device-to-host receiver and decodes the E0
// (extended), F0 (break) and E1 (pause) prefixes. Each complete key event
// is written into a first-word-fall-through FIFO, and the system side
// drains that FIFO with a valid/ready handshake. The block also reports
// BAT success and keyboard error / overrun codes.
//
// Optional build macro: PS2_KBD_TIMEOUT_EN
//   When defined, a prefix state that sees no byte for TIMEOUT_CYC clocks
//   falls back to IDLE, so a lost byte cannot leave the decoder stuck.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   rx_data   received byte
//   rx_rdy    one-cycle strobe, rx_data valid
//   ev_code   head event scan code (0 when FIFO empty)
//   ev_ext    head event had an E0 prefix
//   ev_brk    head event is a key release
//   ev_valid  FIFO not empty
//   ev_ready  consumer pops head when ev_valid & ev_ready
//   ovf       sticky: event dropped because FIFO was full
//   ovf_clr   clears ovf (a same-cycle set wins)
//   bat_ok    one-cycle pulse on AA received in IDLE
//   kbd_err   one-cycle pulse on FC/00/FF received in any state

module ps2_kbd_ctrl #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TIMEOUT_CYC = 200_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_rdy,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_brk,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic       bat_ok,
   output logic       kbd_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0,
      S_SKIP
   } state_t;

   state_t      state, state_n;
   logic [2:0]  skip_cnt, skip_n;
   logic        push;
   logic [9:0]  push_ev;          // {code, ext, brk}
   logic        bat_n, err_n;
   logic        timeout;

   logic [9:0]  mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full, pop, wr_en;

   // ---------------------------------------------------------------
   // Prefix decoder
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         skip_cnt <= '0;
         bat_ok   <= 1'b0;
         kbd_err  <= 1'b0;
      end else begin
         state    <= state_n;
         skip_cnt <= skip_n;
         bat_ok   <= bat_n;
         kbd_err  <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      skip_n  = skip_cnt;
      push    = 1'b0;
      push_ev = '0;
      bat_n   = 1'b0;
      err_n   = 1'b0;

      if (rx_rdy) begin
         // Error codes abort any sequence in progress and never produce an event.
         if (rx_data inside {8'hFC, 8'h00, 8'hFF}) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
            skip_n  = '0;
         end else begin
            case (state)
               S_IDLE: begin
                  case (rx_data)
                     8'hE0: state_n = S_E0;
                     8'hF0: state_n = S_F0;
                     8'hE1: begin
                        state_n = S_SKIP;
                        skip_n  = 3'd7;
                     end
                     8'hAA: bat_n = 1'b1;
                     8'hFA, 8'hEE, 8'hFE: ;
                     default: begin
                        push    = 1'b1;
                        push_ev = {rx_data, 1'b0, 1'b0};
                     end
                  endcase
               end
               S_E0: begin
                  if (rx_data == 8'hF0) begin
                     state_n = S_E0F0;
                  end else begin
                     state_n = S_IDLE;
                     // E0 12 is the fake-shift that some keys emit; drop it.
                     if (rx_data != 8'h12) begin
                        push    = 1'b1;
                        push_ev = {rx_data, 1'b1, 1'b0};
                     end
                  end
               end
               S_F0: begin
                  state_n = S_IDLE;
                  push    = 1'b1;
                  push_ev = {rx_data, 1'b0, 1'b1};
               end
               S_E0F0: begin
                  state_n = S_IDLE;
                  if (rx_data != 8'h12) begin
                     push    = 1'b1;
                     push_ev = {rx_data, 1'b1, 1'b1};
                  end
               end
               S_SKIP: begin
                  // Pause is E1 + 7 further bytes; report it once as {E1, ext}.
                  skip_n = skip_cnt - 3'd1;
                  if (skip_cnt == 3'd1) begin
                     state_n = S_IDLE;
                     push    = 1'b1;
                     push_ev = {8'hE1, 1'b1, 1'b0};
                  end
               end
               default: state_n = S_IDLE;
            endcase
         end
      end else if (timeout) begin
         state_n = S_IDLE;
      end
   end

`ifdef PS2_KBD_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (rst || rx_rdy || state == S_IDLE) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
   logic unused_timeout_cyc;

   assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
   assign timeout            = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Event FIFO (FWFT)
   // ---------------------------------------------------------------
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && ev_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !wr_en) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= push_ev;
      end
   end

   assign ev_valid                 = !empty;
   assign {ev_code, ev_ext, ev_brk} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
